// File: rtl/scan_controller.sv
// -----------------------------------------------------------------------------
// scan_controller
// Four-digit multiplexed display scanner. A prescaler divides clk down to one
// digit slot every CLK_DIV cycles, sel/anode walk ones -> tens -> hundreds ->
// thousands, and newly loaded digits are held in a pending buffer until the
// frame wraps so that a frame never shows a mix of old and new digits.
//
// Optional feature macro: SCAN_LEADING_ZERO_BLANK_EN
//   defined   -> a slot's anode stays high while that digit and every higher
//                digit are zero (the ones slot is always lit)
//   undefined -> all four slots are driven
//
// Start-up behaviour: after reset the anodes stay dark until the first tick.
// That first tick lights slot 0 (anode = 4'b1110) without advancing sel, so
// the visible sequence is 0,1,2,3,0,... with one slot per tick from then on.
// It is not a wrap tick and cannot commit pending data. Re-enabling after a
// pause does not repeat this priming; scanning simply resumes at sel + 1.
// -----------------------------------------------------------------------------
module scan_controller #(
    parameter int CLK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       load,
    input  logic [3:0] ones_in,
    input  logic [3:0] tens_in,
    input  logic [3:0] hundreds_in,
    input  logic [3:0] thousands_in,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic [3:0] thousands,
    output logic [1:0] sel,
    output logic [3:0] anode,
    output logic       frame_done,
    output logic       load_ack
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(CLK_DIV - 1);

    // prescaler and scan position
    logic [CW-1:0] count_r;
    logic [1:0]    sel_r;
    logic [3:0]    anode_r;
    logic          started_r;

    // displayed and pending digits
    logic [3:0]    ones_r;
    logic [3:0]    tens_r;
    logic [3:0]    hundreds_r;
    logic [3:0]    thousands_r;
    logic [3:0]    pend_ones_r;
    logic [3:0]    pend_tens_r;
    logic [3:0]    pend_hundreds_r;
    logic [3:0]    pend_thousands_r;
    logic          pending_r;

    // pulses
    logic          frame_done_r;
    logic          load_ack_r;

    // combinational decode
    logic          tick_s;
    logic          wrap_s;
    logic          commit_s;
    logic [1:0]    sel_next_s;
    logic [3:0]    blank_s;
    logic [3:0]    anode_next_s;

`ifdef SCAN_LEADING_ZERO_BLANK_EN
    // Slot n is blank when digit n and every digit above it are zero;
    // slot 0 is never blanked so a value of zero still shows "0".
    function automatic logic [3:0] leading_zero_mask(
        input logic [3:0] d_thousands,
        input logic [3:0] d_hundreds,
        input logic [3:0] d_tens
    );
        logic z3;
        logic z2;
        logic z1;
        z3 = (d_thousands == 4'd0);
        z2 = z3 && (d_hundreds == 4'd0);
        z1 = z2 && (d_tens == 4'd0);
        return {z3, z2, z1, 1'b0};
    endfunction
`endif

    // Tick, wrap and commit decode plus next scan position and anode pattern
    always_comb begin
        tick_s     = enable && (count_r == COUNT_LAST);
        wrap_s     = tick_s && started_r && (sel_r == 2'd3);
        commit_s   = wrap_s && pending_r;
        if (started_r) begin
            sel_next_s = sel_r + 2'd1;
        end else begin
            sel_next_s = sel_r;
        end
`ifdef SCAN_LEADING_ZERO_BLANK_EN
        blank_s    = leading_zero_mask(thousands_r, hundreds_r, tens_r);
`else
        blank_s    = 4'b0000;
`endif
        anode_next_s = ~(4'b0001 << sel_next_s) | blank_s;
    end

    // Prescaler: counts enabled cycles, clears on tick and while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (tick_s) begin
            count_r <= {CW{1'b0}};
        end else if (enable) begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= {CW{1'b0}};
        end
    end

    // Scan position and anode drive; anodes go dark while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_r     <= 2'd0;
            anode_r   <= 4'b1111;
            started_r <= 1'b0;
        end else if (tick_s) begin
            sel_r     <= sel_next_s;
            anode_r   <= anode_next_s;
            started_r <= 1'b1;
        end else if (!enable) begin
            sel_r     <= sel_r;
            anode_r   <= 4'b1111;
            started_r <= started_r;
        end else begin
            sel_r     <= sel_r;
            anode_r   <= anode_r;
            started_r <= started_r;
        end
    end

    // Pending buffer: every load overwrites it; a commit without a new load clears the flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_ones_r      <= 4'd0;
            pend_tens_r      <= 4'd0;
            pend_hundreds_r  <= 4'd0;
            pend_thousands_r <= 4'd0;
            pending_r        <= 1'b0;
        end else if (load) begin
            pend_ones_r      <= ones_in;
            pend_tens_r      <= tens_in;
            pend_hundreds_r  <= hundreds_in;
            pend_thousands_r <= thousands_in;
            pending_r        <= 1'b1;
        end else if (commit_s) begin
            pending_r        <= 1'b0;
        end else begin
            pending_r        <= pending_r;
        end
    end

    // Displayed digits change only on a committing wrap tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_r      <= 4'd0;
            tens_r      <= 4'd0;
            hundreds_r  <= 4'd0;
            thousands_r <= 4'd0;
        end else if (commit_s) begin
            ones_r      <= pend_ones_r;
            tens_r      <= pend_tens_r;
            hundreds_r  <= pend_hundreds_r;
            thousands_r <= pend_thousands_r;
        end else begin
            ones_r      <= ones_r;
            tens_r      <= tens_r;
            hundreds_r  <= hundreds_r;
            thousands_r <= thousands_r;
        end
    end

    // One-cycle status pulses following a wrap tick and a commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done_r <= 1'b0;
            load_ack_r   <= 1'b0;
        end else begin
            frame_done_r <= wrap_s;
            load_ack_r   <= commit_s;
        end
    end

    assign ones       = ones_r;
    assign tens       = tens_r;
    assign hundreds   = hundreds_r;
    assign thousands  = thousands_r;
    assign sel        = sel_r;
    assign anode      = anode_r;
    assign frame_done = frame_done_r;
    assign load_ack   = load_ack_r;

endmodule

// File: tb/tb_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_scan_controller
// Directed scenarios followed by randomized stimulus, with every output
// compared each cycle against a behavioural model of the scanner.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scan_controller;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       load;
    logic [3:0] ones_in;
    logic [3:0] tens_in;
    logic [3:0] hundreds_in;
    logic [3:0] thousands_in;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [3:0] thousands;
    logic [1:0] sel;
    logic [3:0] anode;
    logic       frame_done;
    logic       load_ack;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    scan_controller #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .load         (load),
        .ones_in      (ones_in),
        .tens_in      (tens_in),
        .hundreds_in  (hundreds_in),
        .thousands_in (thousands_in),
        .ones         (ones),
        .tens         (tens),
        .hundreds     (hundreds),
        .thousands    (thousands),
        .sel          (sel),
        .anode        (anode),
        .frame_done   (frame_done),
        .load_ack     (load_ack)
    );

    // ---------------- behavioural model ----------------
    logic [3:0] m_disp [4];   // index 0 = ones .. 3 = thousands
    logic [3:0] m_pbuf [4];
    bit         m_pend;
    bit         m_started;
    int         m_run;        // consecutive enabled cycles since reset/pause
    int         m_sel;
    logic [3:0] m_anode;
    bit         m_frame;
    bit         m_ack;

    function automatic logic [3:0] model_anode(input int slot);
        logic [3:0] a;
        a = 4'hF;
        a[slot] = 1'b0;
`ifdef SCAN_LEADING_ZERO_BLANK_EN
        begin
            bit all_zero;
            all_zero = 1'b1;
            for (int k = slot; k < 4; k++) if (m_disp[k] != 4'd0) all_zero = 1'b0;
            if (slot != 0 && all_zero) a = 4'hF;
        end
`endif
        return a;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_disp[k] = 4'd0;
            m_pbuf[k] = 4'd0;
        end
        m_pend = 0; m_started = 0; m_run = 0; m_sel = 0;
        m_anode = 4'hF; m_frame = 0; m_ack = 0;
    endtask

    // Predicts the outputs after the coming rising edge from the driven inputs
    task automatic model_edge();
        bit tick, wrap, commit;
        if (rst) begin
            model_reset();
            return;
        end
        tick = 0;
        if (enable) begin
            m_run++;
            tick = (m_run % CLK_DIV) == 0;
        end else begin
            m_run = 0;
        end
        wrap   = tick && m_started && (m_sel == 3);
        commit = wrap && m_pend;
        m_frame = wrap;
        m_ack   = commit;
        if (commit) for (int k = 0; k < 4; k++) m_disp[k] = m_pbuf[k];
        if (load) begin
            m_pbuf[0] = ones_in; m_pbuf[1] = tens_in;
            m_pbuf[2] = hundreds_in; m_pbuf[3] = thousands_in;
            m_pend = 1;
        end else if (commit) begin
            m_pend = 0;
        end
        if (tick) begin
            if (m_started) m_sel = (m_sel + 1) % 4;
            m_started = 1;
            m_anode = model_anode(m_sel);
        end else if (!enable) begin
            m_anode = 4'hF;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            chk("model_sel",        sel,        m_sel);
            chk("model_anode",      anode,      m_anode);
            chk("model_ones",       ones,       m_disp[0]);
            chk("model_tens",       tens,       m_disp[1]);
            chk("model_hundreds",   hundreds,   m_disp[2]);
            chk("model_thousands",  thousands,  m_disp[3]);
            chk("model_frame_done", frame_done, m_frame);
            chk("model_load_ack",   load_ack,   m_ack);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_in(input logic [3:0] th, input logic [3:0] hu,
                          input logic [3:0] te, input logic [3:0] on);
        thousands_in = th; hundreds_in = hu; tens_in = te; ones_in = on;
    endtask

    // Advances until the next rising edge is a wrap tick
    task automatic wait_wrap();
        bit found;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (enable && m_started && m_sel == 3 && (m_run % CLK_DIV) == CLK_DIV - 1) found = 1;
            else cyc();
        end
        chk("wrap_reached", found, 1);
    endtask

    task automatic pin_digits(input string name, input logic [15:0] exp);
        chk(name, {thousands, hundreds, tens, ones}, exp);
    endtask

    function automatic logic [3:0] rand_digit();
        logic [3:0] d;
        d = 4'($urandom_range(15, 0));
        if ($urandom_range(2, 0) == 0) d = 4'd0;
        return d;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acks;
        bit found;
        rst = 1'b1; enable = 1'b0; load = 1'b0;
        set_in(4'd0, 4'd0, 4'd0, 4'd0);
        model_reset();
        repeat (3) @(negedge clk);
        chk_on = 1'b1;

        // Reset state
        chk("rst_sel", sel, 2'd0);
        chk("rst_anode", anode, 4'b1111);
        pin_digits("rst_digits", 16'h0000);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_load_ack", load_ack, 1'b0);

        // Scan after reset release, with a mid-frame load of 4,3,2,1
        rst = 1'b0; enable = 1'b1;
        repeat (3) cyc();
        chk("pre_tick_anode", anode, 4'b1111);
        cyc();
        chk("first_tick_sel", sel, 2'd0);
        chk("first_tick_anode", anode, 4'b1110);
        cyc();
        load = 1'b1; set_in(4'd4, 4'd3, 4'd2, 4'd1);
        cyc();
        load = 1'b0;
        repeat (2) cyc();
        chk("slot1_sel", sel, 2'd1);
        chk("slot1_anode", anode, 4'b1101);
        pin_digits("held_before_wrap", 16'h0000);
        repeat (4) cyc();
        chk("slot2_anode", anode, 4'b1011);
        repeat (4) cyc();
        chk("slot3_sel", sel, 2'd3);
        chk("slot3_anode", anode, 4'b0111);
        chk("no_frame_yet", frame_done, 1'b0);
        repeat (4) cyc();
        chk("wrap_sel", sel, 2'd0);
        chk("wrap_anode", anode, 4'b1110);
        pin_digits("commit_1234", 16'h4321);
        chk("wrap_frame_done", frame_done, 1'b1);
        chk("wrap_load_ack", load_ack, 1'b1);
        cyc();
        chk("frame_done_one_cycle", frame_done, 1'b0);
        chk("load_ack_one_cycle", load_ack, 1'b0);

        // Load coinciding with a committing wrap tick
        load = 1'b1; set_in(4'd7, 4'd7, 4'd7, 4'd7);
        cyc();
        load = 1'b0;
        wait_wrap();
        load = 1'b1; set_in(4'd5, 4'd5, 4'd5, 4'd5);
        cyc();
        load = 1'b0;
        pin_digits("old_buffer_committed", 16'h7777);
        chk("coincident_ack", load_ack, 1'b1);
        wait_wrap();
        cyc();
        pin_digits("new_buffer_committed", 16'h5555);
        chk("second_ack", load_ack, 1'b1);

        // Pause at sel = 2 for 10 cycles
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_sel == 2 && (m_run % CLK_DIV) == 1) found = 1;
            else cyc();
        end
        chk("slot2_reached", found, 1);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("pause_frame_done", frame_done, 1'b0);
        end
        chk("pause_anode", anode, 4'b1111);
        chk("pause_sel", sel, 2'd2);
        enable = 1'b1;
        repeat (CLK_DIV - 1) cyc();
        chk("resume_wait_sel", sel, 2'd2);
        cyc();
        chk("resume_sel", sel, 2'd3);
        chk("resume_anode", anode, 4'b0111);

        // Reset with data pending
        load = 1'b1; set_in(4'd9, 4'd9, 4'd9, 4'd9);
        cyc();
        load = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        chk("async_rst_sel", sel, 2'd0);
        chk("async_rst_anode", anode, 4'b1111);
        pin_digits("async_rst_digits", 16'h0000);
        chk("async_rst_frame_done", frame_done, 1'b0);
        chk("async_rst_load_ack", load_ack, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
        acks = 0;
        repeat (40) begin
            cyc();
            if (load_ack) acks++;
        end
        chk("no_ack_after_rst", acks, 0);
        pin_digits("pending_discarded", 16'h0000);

        // Leading-zero display 0,0,4,0
        load = 1'b1; set_in(4'd0, 4'd0, 4'd4, 4'd0);
        cyc();
        load = 1'b0;
        wait_wrap();
        cyc();
        pin_digits("commit_0040", 16'h0040);
        chk("lz_slot0", anode, 4'b1110);
        repeat (4) cyc();
        chk("lz_slot1", anode, 4'b1101);
        repeat (4) cyc();
`ifdef SCAN_LEADING_ZERO_BLANK_EN
        chk("lz_slot2", anode, 4'b1111);
`else
        chk("lz_slot2", anode, 4'b1011);
`endif
        repeat (4) cyc();
`ifdef SCAN_LEADING_ZERO_BLANK_EN
        chk("lz_slot3", anode, 4'b1111);
`else
        chk("lz_slot3", anode, 4'b0111);
`endif
        repeat (4) cyc();
        chk("lz_slot0_again", anode, 4'b1110);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(15, 0) != 0);
            load   = ($urandom_range(7, 0) == 0);
            set_in(rand_digit(), rand_digit(), rand_digit(), rand_digit());
            rst    = ($urandom_range(499, 0) == 0);
            cyc();
        end
        rst = 1'b0; load = 1'b0;
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
